// File: rtl/loop_sampler.sv
// loop_sampler: record/playback sample memory with looped playback and
// saturating overdub. One single-port RAM holds the loop; a small controller
// sequences record writes, playback reads and overdub read-modify-writes.
module loop_sampler #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              sample_tick,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              overdub_en,
  input  logic [DATA_W-1:0] in_sample,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   loop_len,
  output logic              full
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10
  } state_t;

  state_t            cur_state, nxt_state;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W:0]   len_d;
  logic              full_d;
  logic              show, show_d;
  logic              rec_we, play_rd, od_cap;

  logic              wb_pending;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_in;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W:0]   mix_sum;
  logic [DATA_W-1:0] mix_sat;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  // Storage: no reset, so a recorded loop survives Reset
  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state logic: commands take priority and swallow any tick in the same cycle
  always_comb begin
    nxt_state = cur_state;
    ptr_d     = ptr;
    len_d     = loop_len;
    full_d    = full;
    rec_we    = 1'b0;
    play_rd   = 1'b0;
    od_cap    = 1'b0;
    if (stop) begin
      nxt_state = IDLE;
    end else if (rec_start) begin
      nxt_state = REC;
      ptr_d     = '0;
      len_d     = '0;
      full_d    = 1'b0;
    end else if (play_start) begin
      if (loop_len != '0) begin
        nxt_state = PLAY;
        ptr_d     = '0;
      end
    end else if (sample_tick) begin
      case (cur_state)
        REC: begin
          rec_we = 1'b1;
          len_d  = loop_len + 1'b1;
          if (ptr == '1) begin
            ptr_d     = '0;
            full_d    = 1'b1;
            nxt_state = IDLE;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end
        PLAY: begin
          play_rd = 1'b1;
          od_cap  = overdub_en;
          ptr_d   = ({1'b0, ptr} == loop_len - 1'b1) ? '0 : ptr + 1'b1;
        end
        default: ;
      endcase
    end
    show_d = play_rd ? 1'b1 : ((nxt_state == PLAY) ? show : 1'b0);
  end

  // Controller registers; a pending overdub write is dropped by Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur_state  <= IDLE;
      ptr        <= '0;
      loop_len   <= '0;
      full       <= 1'b0;
      show       <= 1'b0;
      out_valid  <= 1'b0;
      wb_pending <= 1'b0;
      wb_addr    <= '0;
      wb_in      <= '0;
    end else begin
      cur_state  <= nxt_state;
      ptr        <= ptr_d;
      loop_len   <= len_d;
      full       <= full_d;
      show       <= show_d;
      out_valid  <= play_rd;
      wb_pending <= od_cap;
      if (od_cap) begin
        wb_addr <= ptr;
        wb_in   <= in_sample;
      end
    end
  end

  // Overdub mix: widen by one bit, then clamp to the signed sample range
  always_comb begin
    mix_sum = {rd_data[DATA_W-1], rd_data} + {wb_in[DATA_W-1], wb_in};
    if (mix_sum[DATA_W] != mix_sum[DATA_W-1]) begin
      mix_sat = mix_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      mix_sat = mix_sum[DATA_W-1:0];
    end
  end

  assign ram_we    = wb_pending | rec_we;
  assign ram_addr  = wb_pending ? wb_addr : ptr;
  assign ram_wdata = wb_pending ? mix_sat : in_sample;

  // Single-port RAM; tick spacing keeps write-back and reads in separate cycles
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (play_rd) begin
      rd_data <= mem[ram_addr];
    end
  end

  assign out_sample = show ? rd_data : '0;
  assign state      = cur_state;

endmodule

// File: tb/tb_loop_sampler.sv
// Testbench for loop_sampler: directed scenarios plus random command/tick
// traffic, all checked against a behavioural loop model.
module tb_loop_sampler;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int SMAX   = 511;
  localparam int SMIN   = -512;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              sample_tick = 1'b0;
  logic              rec_start = 1'b0;
  logic              play_start = 1'b0;
  logic              stop = 1'b0;
  logic              overdub_en = 1'b0;
  logic [DATA_W-1:0] in_sample = '0;
  logic [DATA_W-1:0] out_sample;
  logic              out_valid;
  logic [1:0]        state;
  logic [ADDR_W:0]   loop_len;
  logic              full;

  int testsRun = 0;
  int testsFailed = 0;

  int mState;
  int mLen;
  int mPtr;
  int mFull;
  int mMem [DEPTH];

  loop_sampler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .rec_start(rec_start),
    .play_start(play_start), .stop(stop), .overdub_en(overdub_en),
    .in_sample(in_sample), .out_sample(out_sample), .out_valid(out_valid),
    .state(state), .loop_len(loop_len), .full(full)
  );

  // 10 ns clock
  always #5 Clk = ~Clk;

  function automatic int sat(input int s);
    if (s > SMAX) return SMAX;
    if (s < SMIN) return SMIN;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_state"}, int'(state), mState);
    checkOutput({tag, "_len"}, int'(loop_len), mLen);
    checkOutput({tag, "_full"}, int'(full), mFull);
  endtask

  function automatic void modelReset();
    mState = 0;
    mLen   = 0;
    mPtr   = 0;
    mFull  = 0;
  endfunction

  // One active cycle of inputs, then check outputs one cycle after the edge
  task automatic applyStimulus(input string tag, input bit tk, input bit rec,
                               input bit ply, input bit stp, input bit od, input int v);
    int expOut;
    bit expValid;
    expOut = 0;
    expValid = 1'b0;
    @(negedge Clk);
    checkOutput({tag, "_idlevalid"}, int'(out_valid), 0);
    sample_tick = tk;
    rec_start   = rec;
    play_start  = ply;
    stop        = stp;
    overdub_en  = od;
    in_sample   = v[DATA_W-1:0];
    if (stp) begin
      mState = 0;
    end else if (rec) begin
      mState = 1; mPtr = 0; mLen = 0; mFull = 0;
    end else if (ply) begin
      if (mLen != 0) begin
        mState = 2; mPtr = 0;
      end
    end else if (tk) begin
      if (mState == 1) begin
        mMem[mPtr] = v;
        mPtr++;
        mLen++;
        if (mLen == DEPTH) begin
          mFull = 1; mState = 0; mPtr = 0;
        end
      end else if (mState == 2) begin
        expOut = mMem[mPtr];
        expValid = 1'b1;
        if (od) mMem[mPtr] = sat(mMem[mPtr] + v);
        mPtr = (mPtr + 1) % mLen;
      end
    end
    @(negedge Clk);
    sample_tick = 1'b0;
    rec_start   = 1'b0;
    play_start  = 1'b0;
    stop        = 1'b0;
    overdub_en  = 1'b0;
    in_sample   = '0;
    checkModel(tag);
    checkOutput({tag, "_valid"}, int'(out_valid), int'(expValid));
    if (expValid) checkOutput({tag, "_out"}, int'($signed(out_sample)), expOut);
    else if (mState != 2) checkOutput({tag, "_out0"}, int'($signed(out_sample)), 0);
  endtask

  initial begin
    int addr;
    int expOut;
    int v;
    int r;
    modelReset();
    for (int i = 0; i < DEPTH; i++) mMem[i] = 0;

    // Reset values
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checkModel("reset");
    checkOutput("reset_out", int'(out_sample), 0);
    checkOutput("reset_valid", int'(out_valid), 0);

    // Record 1..5, stop, then 12 looped playback ticks
    applyStimulus("rec", 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus("rec5", 1, 0, 0, 0, 0, i);
    applyStimulus("stop", 0, 0, 0, 1, 0, 0);
    checkOutput("len5", int'(loop_len), 5);
    applyStimulus("play", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus("play12", 1, 0, 0, 0, 0, 0);

    // Overdub saturation: 500,-500,3 mixed with 100,-100,4
    applyStimulus("rec", 0, 1, 0, 0, 0, 0);
    applyStimulus("odrec", 1, 0, 0, 0, 0, 500);
    applyStimulus("odrec", 1, 0, 0, 0, 0, -500);
    applyStimulus("odrec", 1, 0, 0, 0, 0, 3);
    applyStimulus("stop", 0, 0, 0, 1, 0, 0);
    applyStimulus("play", 0, 0, 1, 0, 0, 0);
    applyStimulus("odmix", 1, 0, 0, 0, 1, 100);
    applyStimulus("odmix", 1, 0, 0, 0, 1, -100);
    applyStimulus("odmix", 1, 0, 0, 0, 1, 4);
    checkOutput("od_model0", mMem[0], 511);
    checkOutput("od_model1", mMem[1], -512);
    checkOutput("od_model2", mMem[2], 7);
    for (int i = 0; i < 3; i++) applyStimulus("odpass2", 1, 0, 0, 0, 0, 0);

    // Priority and empty loop
    applyStimulus("prio", 0, 1, 1, 1, 0, 0);
    checkOutput("prio_state", int'(state), 0);
    applyStimulus("rec", 0, 1, 0, 0, 0, 0);
    applyStimulus("stop", 0, 0, 0, 1, 0, 0);
    applyStimulus("empty_play", 0, 0, 1, 0, 0, 0);
    checkOutput("empty_state", int'(state), 0);

    // Fill all 16 entries, then an ignored 17th tick
    applyStimulus("rec", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1, 0, 0, 0, 0, i * 30 - 200);
    checkOutput("fill_full", int'(full), 1);
    checkOutput("fill_len", int'(loop_len), 16);
    checkOutput("fill_state", int'(state), 0);
    applyStimulus("fill17", 1, 0, 0, 0, 0, 333);
    checkOutput("fill17_ram0", int'($signed(dut.mem[0])), mMem[0]);

    // Tick coincident with rec_start while playing is dropped
    applyStimulus("play", 0, 0, 1, 0, 0, 0);
    applyStimulus("playf", 1, 0, 0, 0, 0, 0);
    applyStimulus("playf", 1, 0, 0, 0, 0, 0);
    applyStimulus("rectick", 1, 1, 0, 0, 0, 99);
    checkOutput("rectick_len", int'(loop_len), 0);
    applyStimulus("rec77", 1, 0, 0, 0, 0, 77);
    applyStimulus("stop", 0, 0, 0, 1, 0, 0);
    applyStimulus("play", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("len1", 1, 0, 0, 0, 0, 0);

    // Reset asserted in the overdub write-back cycle
    applyStimulus("rec", 0, 1, 0, 0, 0, 0);
    applyStimulus("rrec", 1, 0, 0, 0, 0, 10);
    applyStimulus("rrec", 1, 0, 0, 0, 0, 20);
    applyStimulus("rrec", 1, 0, 0, 0, 0, 30);
    applyStimulus("stop", 0, 0, 0, 1, 0, 0);
    applyStimulus("play", 0, 0, 1, 0, 0, 0);
    applyStimulus("rplay", 1, 0, 0, 0, 0, 0);
    applyStimulus("rplay", 1, 0, 0, 0, 0, 0);
    @(negedge Clk);
    addr = mPtr;
    expOut = mMem[mPtr];
    sample_tick = 1'b1;
    overdub_en  = 1'b1;
    in_sample   = 10'd100;
    @(negedge Clk);
    sample_tick = 1'b0;
    overdub_en  = 1'b0;
    in_sample   = '0;
    checkOutput("rst_pre_valid", int'(out_valid), 1);
    checkOutput("rst_pre_out", int'($signed(out_sample)), expOut);
    Reset = 1'b1;
    #1;
    modelReset();
    checkModel("rst_async");
    checkOutput("rst_async_out", int'(out_sample), 0);
    checkOutput("rst_async_valid", int'(out_valid), 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    checkOutput("rst_ram", int'($signed(dut.mem[addr])), mMem[addr]);
    applyStimulus("rec", 0, 1, 0, 0, 0, 0);
    applyStimulus("rerec", 1, 0, 0, 0, 0, -7);
    applyStimulus("rerec", 1, 0, 0, 0, 0, 8);
    applyStimulus("stop", 0, 0, 0, 1, 0, 0);
    applyStimulus("play", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("replay", 1, 0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      v = int'($urandom_range(0, 1023)) - 512;
      if (r == 0) applyStimulus("rnd_rec", 0, 1, 0, 0, 0, 0);
      else if (r == 1) applyStimulus("rnd_play", 0, 0, 1, 0, 0, 0);
      else if (r == 2) applyStimulus("rnd_stop", 0, 0, 0, 1, 0, 0);
      else if (r == 3) applyStimulus("rnd_cmdtick", 1, 0, 1, 0, 0, v);
      else applyStimulus("rnd_tick", 1, 0, 0, 0, (($urandom & 1) == 1), v);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/loop_sampler.md
# loop_sampler

Parametrised record/playback sample memory with an internal controller. Records a stream of signed audio samples into on-chip block RAM on each sample strobe and remembers the recorded length. Plays the loop back continuously, wrapping at that length, and can overdub new input onto the loop with a saturating mix. Sits between the audio sample source/sink and the pad-control logic, which issues record, play and stop commands.

## Interface
- DATA_W, 10, sample width in bits; samples are two's complement.
- ADDR_W, 18, address width; DEPTH = 2^ADDR_W samples.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe, one per audio sample period; consecutive ticks are at least 2 cycles apart.
- rec_start  in  1  one-cycle command: begin recording at address 0.
- play_start  in  1  one-cycle command: begin looped playback at address 0.
- stop  in  1  one-cycle command: return to IDLE.
- overdub_en  in  1  level; while in PLAY, mix in_sample into the loop.
- in_sample  in  DATA_W  input sample, sampled on a tick cycle.
- out_sample  out  DATA_W  playback sample, registered.
- out_valid  out  1  one-cycle pulse when out_sample updates.
- state  out  2  00 IDLE, 01 REC, 10 PLAY.
- loop_len  out  ADDR_W+1  number of valid recorded samples, 0..DEPTH.
- full  out  1  set when a recording filled all DEPTH entries.

## Operation
- Storage is a single-port DEPTH x DATA_W synchronous RAM, inferred as block RAM. It has no reset, so its contents survive Reset.
- Command priority: stop > rec_start > play_start.
- A command cycle drops any sample_tick in that same cycle. The new state acts from the next tick.
- IDLE: ignores ticks. out_sample = 0.
- rec_start (any state):
  - go to REC, ptr = 0, loop_len = 0, full = 0.
- REC, on tick:
  - RAM[ptr] <= in_sample; ptr++; loop_len++.
  - On the tick that writes address DEPTH-1: loop_len = DEPTH, full = 1, go to IDLE automatically.
- stop in REC: loop_len keeps the count written so far; go to IDLE.
- play_start:
  - With loop_len = 0: ignored, state unchanged.
  - Otherwise: go to PLAY, ptr = 0.
- PLAY, on tick:
  - Read RAM[ptr].
  - Next cycle: out_sample = read data, out_valid = 1.
  - ptr advances to ptr+1, or to 0 if ptr = loop_len-1.
- Overdub (PLAY with overdub_en = 1 on the tick cycle):
  - in_sample is captured on the tick.
  - Next cycle: RAM[old ptr] <= sat(read + captured in_sample), a read-modify-write.
  - out_sample shows the pre-mix read data.
- Saturation: the sum is computed in DATA_W+1 bits, then clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- stop or rec_start arriving in the write-back cycle of an overdub: the pending write still completes, then the command takes effect.
- Entering IDLE clears out_sample to 0 on the next cycle. full and loop_len hold.

## Timing
- Reset values: state = IDLE, ptr = 0, loop_len = 0, full = 0, out_sample = 0, out_valid = 0.
- Record write: RAM written at the tick edge. loop_len is visible 1 cycle after the tick.
- Playback latency: tick at cycle T gives out_sample/out_valid at T+1. out_valid is high for exactly 1 cycle.
- Overdub write-back occurs at T+1. Ticks spaced 2 cycles apart guarantee no port conflict.
- Reset asserted mid-REC/PLAY: outputs return to reset values immediately (asynchronously). A pending overdub write is discarded.
- Wrap: with loop_len = L, ticks play addresses 0..L-1, 0, ... indefinitely. L = 1 replays address 0 on every tick.

## Test plan
- Record 5 ticks with in_sample 1, 2, 3, 4, 5, then stop, then play_start and 12 ticks. Required: loop_len = 5; out_sample sequence 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2, each 1 cycle after its tick, with out_valid pulses.
- Overdub saturation (DATA_W = 10): loop holds 500, -500, 3. Play one pass with overdub_en = 1 and in_sample 100, -100, 4. Required on the next pass: 511, -512, 7.
- Fill (ADDR_W = 4): record 16 ticks. Required: full = 1, loop_len = 16, state = IDLE after the 16th tick. A 17th tick writes nothing.
- Priority and empty: stop, rec_start and play_start in the same cycle → IDLE. play_start with loop_len = 0 → state stays IDLE.
- Tick coincident with rec_start in PLAY: that tick is dropped. Required: loop_len = 0 and ptr = 0 afterwards; the next tick writes address 0.
- Reset asserted during PLAY at the overdub write-back cycle. Required: all outputs take their reset values immediately, RAM at that address is unchanged, and the loop can be re-recorded after reset deasserts.
